clock_div_ctrl: RTL and testbench

- Two-channel programmable clock-divider controller driven by the 50 MHz system clock.
- Each channel produces a square-wave output whose half-period is configured at run time through a valid/ready port.
- Each channel is started and stopped by command pulses, and stops without runt pulses.
- Replaces fixed-constant dividers wherever the board needs retunable slow clocks, such as display scan or blink rates.

---
 rtl/clock_div_pkg.sv | 15 +
 rtl/div_channel.sv | 116 +++++++++++
 rtl/clock_div_ctrl.sv | 54 +++++
 tb/tb_clock_div_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants and state encoding for the two-channel clock-divider controller.
package clock_div_pkg;

  localparam int unsigned NUM_CH         = 2;
  localparam int unsigned DEFAULT_WIDTH  = 26;
  localparam int unsigned DEFAULT_HALF_X = 50_000_000;
  localparam int unsigned DEFAULT_HALF_Y = 25_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

endpackage

// File: rtl/div_channel.sv
// One divider channel: run/drain FSM, half-period counter, and a shadow register
// so that retuning takes effect only on a toggle edge.
module div_channel
  import clock_div_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF_X)
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             out,
  output logic             tick,
  output logic             pending,
  output logic             active
);

  ch_state_e        state, state_n;
  logic [WIDTH-1:0] ctr, ctr_n;
  logic [WIDTH-1:0] half, half_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic             out_n, tick_n, pending_n;
  logic [WIDTH-1:0] cfg_clamped;
  logic             hit;

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state   <= ST_IDLE;
      ctr     <= '0;
      half    <= DEF_HALF;
      shadow  <= '0;
      pending <= 1'b0;
      out     <= 1'b0;
      tick    <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      ctr     <= ctr_n;
      half    <= half_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      out     <= out_n;
      tick    <= tick_n;
      active  <= (state_n != ST_IDLE);
    end
  end

  // >= rather than == so an out-of-range counter recovers on the next edge
  assign cfg_clamped = (cfg_half == '0) ? WIDTH'(1) : cfg_half;
  assign hit         = (ctr >= half - WIDTH'(1));

  always_comb begin
    state_n   = state;
    ctr_n     = ctr;
    half_n    = half;
    shadow_n  = shadow;
    pending_n = pending;
    out_n     = out;
    tick_n    = 1'b0;

    if (state == ST_IDLE) begin
      out_n = 1'b0;
      ctr_n = '0;
      // a shadow left over from a stop that raced a config is applied here
      if (pending) begin
        half_n    = shadow;
        pending_n = 1'b0;
      end
      if (start && !stop) state_n = ST_RUN;
    end else begin
      if (hit) begin
        ctr_n  = '0;
        out_n  = ~out;
        tick_n = 1'b1;
        if (pending) begin
          half_n    = shadow;
          pending_n = 1'b0;
        end
      end else begin
        ctr_n = ctr + WIDTH'(1);
      end

      if (state == ST_RUN) begin
        if (stop) begin
          if (!out) begin
            // low phase: stop at once, no toggle even if one was due
            state_n = ST_IDLE;
            ctr_n   = '0;
            out_n   = 1'b0;
            tick_n  = 1'b0;
            half_n    = half;
            pending_n = pending;
          end else begin
            state_n = hit ? ST_IDLE : ST_DRAIN;
          end
        end
      end else begin
        if (start && !stop) state_n = ST_RUN;
        else if (hit)       state_n = ST_IDLE;
      end
    end

    if (cfg_we) begin
      if (state == ST_IDLE) begin
        half_n = cfg_clamped;
      end else begin
        shadow_n  = cfg_clamped;
        pending_n = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Two-channel programmable clock divider: config routing, ready mux and busy flag.
module clock_div_ctrl
  import clock_div_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEF_HALF_X = WIDTH'(DEFAULT_HALF_X),
  parameter logic [WIDTH-1:0] DEF_HALF_Y = WIDTH'(DEFAULT_HALF_Y)
) (
  input  logic              clk,
  input  logic              ar,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_ch,
  input  logic [WIDTH-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic              x,
  output logic              y,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic              busy
);

  logic [NUM_CH-1:0] cfg_we;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] active;

  assign cfg_ready = ~pending[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == 1'(i));

    div_channel #(
      .WIDTH    (WIDTH),
      .DEF_HALF ((i == 0) ? DEF_HALF_X : DEF_HALF_Y)
    ) u_ch (
      .clk      (clk),
      .ar       (ar),
      .start    (start[i]),
      .stop     (stop[i]),
      .cfg_we   (cfg_we[i]),
      .cfg_half (cfg_half),
      .out      (out[i]),
      .tick     (tick[i]),
      .pending  (pending[i]),
      .active   (active[i])
    );
  end

  assign x    = out[0];
  assign y    = out[1];
  assign busy = |active;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: expected toggle edges are queued per channel
// when stimulus is applied and matched against tick/x/y as they occur.
module tb_clock_div_ctrl;

  logic        clk = 1'b0;
  logic        ar;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ch;
  logic [25:0] cfg_half;
  logic [1:0]  start;
  logic [1:0]  stop;
  logic        x;
  logic        y;
  logic [1:0]  tick;
  logic [1:0]  pending;
  logic        busy;

  clock_div_ctrl #(
    .WIDTH      (26),
    .DEF_HALF_X (26'd7),
    .DEF_HALF_Y (26'd5)
  ) dut (
    .clk       (clk),
    .ar        (ar),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .start     (start),
    .stop      (stop),
    .x         (x),
    .y         (y),
    .tick      (tick),
    .pending   (pending),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int   edge_no;
    logic val;
  } ev_t;

  ev_t  q0[$];
  ev_t  q1[$];
  int   edge_n = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic prev_x = 1'b0;
  logic prev_y = 1'b0;
  int   e;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int edge_no, input logic val);
    ev_t ev;
    ev.edge_no = edge_no;
    ev.val     = val;
    if (ch == 0) q0.push_back(ev);
    else         q1.push_back(ev);
  endtask

  task automatic observe();
    ev_t ev;
    chk("x_tick_align", 32'(x !== prev_x), 32'(tick[0]));
    chk("y_tick_align", 32'(y !== prev_y), 32'(tick[1]));
    if (q0.size() != 0 && q0[0].edge_no < edge_n) begin
      ev = q0.pop_front();
      chk("x_overdue", 32'(edge_n), 32'(ev.edge_no));
    end
    if (q1.size() != 0 && q1[0].edge_no < edge_n) begin
      ev = q1.pop_front();
      chk("y_overdue", 32'(edge_n), 32'(ev.edge_no));
    end
    if (tick[0]) begin
      chk("tick0_queued", 32'(q0.size() != 0), 32'(1));
      if (q0.size() != 0) begin
        ev = q0.pop_front();
        chk("x_edge", 32'(edge_n), 32'(ev.edge_no));
        chk("x_val", 32'(x), 32'(ev.val));
      end
    end
    if (tick[1]) begin
      chk("tick1_queued", 32'(q1.size() != 0), 32'(1));
      if (q1.size() != 0) begin
        ev = q1.pop_front();
        chk("y_edge", 32'(edge_n), 32'(ev.edge_no));
        chk("y_val", 32'(y), 32'(ev.val));
      end
    end
    prev_x = x;
    prev_y = y;
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic cyc(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic cfg_write(input logic ch, input logic [25:0] v);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = v;
    tick_cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    ar = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_half = '0; start = '0; stop = '0;
    #1;
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    cyc(2);
    ar = 1'b0;
    cyc(100);
    chk("idle_x", 32'(x), 0);
    chk("idle_y", 32'(y), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cfg_ready", 32'(cfg_ready), 1);

    // basic run on ch0, half = 3
    cfg_write(1'b0, 26'd3);
    chk("idle_cfg_no_pending", 32'(pending), 0);
    start[0] = 1'b1; tick_cycle(); start = '0; e = edge_n;
    push(0, e + 3, 1'b1); push(0, e + 6, 1'b0); push(0, e + 9, 1'b1);
    chk("run_busy", 32'(busy), 1);
    cyc(9);
    chk("run_x_high", 32'(x), 1);
    chk("run_no_pending", 32'(pending), 0);

    // shadow retune to 5 mid half-period
    cyc(1);
    chk("pre_cfg_ready", 32'(cfg_ready), 1);
    cfg_write(1'b0, 26'd5);
    chk("shadow_pending", 32'(pending), 32'(2'b01));
    chk("shadow_ready_ch0", 32'(cfg_ready), 0);
    cfg_ch = 1'b1; #1;
    chk("shadow_ready_ch1", 32'(cfg_ready), 1);
    cfg_ch = 1'b0;
    push(0, e + 12, 1'b0); push(0, e + 17, 1'b1); push(0, e + 22, 1'b0);
    cyc(1);
    chk("shadow_applied", 32'(pending), 0);
    cyc(10);
    stop[0] = 1'b1; tick_cycle(); stop = '0;
    chk("stop_low_busy", 32'(busy), 0);

    // drain on ch1, half = 4
    cfg_write(1'b1, 26'd4);
    start[1] = 1'b1; tick_cycle(); start = '0; e = edge_n;
    push(1, e + 4, 1'b1); push(1, e + 8, 1'b0);
    cyc(4);
    chk("drain_y_high", 32'(y), 1);
    stop[1] = 1'b1; tick_cycle(); stop = '0;
    chk("drain_busy", 32'(busy), 1);
    cyc(3);
    chk("drain_done_y", 32'(y), 0);
    chk("drain_done_busy", 32'(busy), 0);
    start[1] = 1'b1; tick_cycle(); start = '0;
    cyc(2);
    stop[1] = 1'b1; tick_cycle(); stop = '0;
    chk("stop_low_idle", 32'(busy), 0);
    cyc(6);

    // start+stop together in RUN, then restart from DRAIN (ch0 half = 5)
    start[0] = 1'b1; tick_cycle(); start = '0; e = edge_n;
    push(0, e + 5, 1'b1); push(0, e + 10, 1'b0); push(0, e + 15, 1'b1); push(0, e + 20, 1'b0);
    cyc(5);
    start[0] = 1'b1; stop[0] = 1'b1; tick_cycle(); start = '0; stop = '0;
    chk("both_drain_busy", 32'(busy), 1);
    start[0] = 1'b1; tick_cycle(); start = '0;
    cyc(8);
    chk("restart_x_high", 32'(x), 1);
    stop[0] = 1'b1; tick_cycle(); stop = '0;
    cyc(4);
    chk("restart_done_busy", 32'(busy), 0);

    // half = 0 clamps to 1 on ch1; stop on a low-phase due edge wins
    cfg_write(1'b1, 26'd0);
    start[1] = 1'b1; tick_cycle(); start = '0; e = edge_n;
    for (int i = 1; i <= 6; i++) push(1, e + i, 1'(i % 2));
    cyc(6);
    stop[1] = 1'b1; tick_cycle(); stop = '0;
    chk("clamp_stop_y", 32'(y), 0);
    chk("clamp_stop_tick", 32'(tick), 0);
    chk("clamp_stop_busy", 32'(busy), 0);

    // async reset mid-run with a pending shadow
    start[0] = 1'b1; tick_cycle(); start = '0; e = edge_n;
    push(0, e + 5, 1'b1);
    cyc(6);
    cfg_write(1'b0, 26'd9);
    chk("pre_rst_pending", 32'(pending), 32'(2'b01));
    chk("pre_rst_q0", 32'(q0.size()), 0);
    #2 ar = 1'b1;
    #1;
    chk("arst_x", 32'(x), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cfg_ready", 32'(cfg_ready), 1);
    #1 ar = 1'b0;
    #1;
    prev_x = x;
    prev_y = y;

    // defaults restored: ch0 half 7, ch1 half 5
    start = 2'b11; tick_cycle(); start = '0; e = edge_n;
    push(0, e + 7, 1'b1); push(1, e + 5, 1'b1);
    cyc(8);
    chk("final_q0_empty", 32'(q0.size()), 0);
    chk("final_q1_empty", 32'(q1.size()), 0);
    chk("final_x", 32'(x), 1);
    chk("final_y", 32'(y), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
